instr_decode_reg: RTL
=====================

INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000000: instruction word presented on the field outputs while empty.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port flush, input, 1: synchronous discard of all held instructions (branch/jump redirect).
REQ-005 SHALL have port in_valid, input, 1: fetch stage presents an instruction.
REQ-006 SHALL have port in_instr, input, 32: fetched instruction word.
REQ-007 SHALL have port in_pc, input, 32: PC of in_instr.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_instr this cycle.
REQ-009 SHALL have port out_valid, output, 1: decoded instruction available.
REQ-010 SHALL have port out_ready, input, 1: downstream (register read / sign extender / ALU stage) consumes this cycle.
REQ-011 SHALL have port out_pc, output, 32: PC of the presented instruction.
REQ-012 SHALL have ports opcode (6), rs (5), rt (5), rd (5), shamt (5), funct (6), imm16 (16), jaddr (26), all outputs: MIPS fields of the presented word (bits 31:26, 25:21, 20:16, 15:11, 10:6, 5:0, 15:0, 25:0).
REQ-013 SHALL have port is_rtype, output, 1: high when opcode == 6'b000000 and out_valid.

Function
REQ-014 SHALL hold up to two instructions: main entry (drives outputs) and skid entry (overflow).
REQ-015 SHALL accept an instruction when in_valid && in_ready; SHALL consume when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !skid_valid, from registered state only (no combinational path from out_ready).
REQ-017 SHALL drive out_valid = main_valid.
REQ-018 Latency: an instruction accepted in cycle N SHALL appear on the outputs with out_valid=1 in cycle N+1 when main is empty or consumed in cycle N.
REQ-019 Push, main empty: SHALL load main.
REQ-020 Push and pop same cycle, skid empty: SHALL load main with new word; skid stays empty.
REQ-021 Push, main valid and not popped: SHALL load skid.
REQ-022 Pop with skid valid: SHALL move skid to main, clear skid; in_ready rises next cycle.
REQ-023 Pop, no push, skid empty: SHALL clear main_valid and set main word to NOP_INSTR, out_pc to 0.
REQ-024 Sustained in_valid=1, out_ready=1 SHALL give one instruction per cycle with no bubbles.
REQ-025 Order SHALL be preserved: outputs leave in acceptance order; no loss, no duplication.
REQ-026 Field outputs SHALL be pure bit slices of the main word (no extension here; imm16 is sign-extended downstream).
REQ-027 While out_valid=0, field outputs SHALL reflect NOP_INSTR and is_rtype SHALL be 0.
REQ-028 Held outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 flush=1 SHALL, at the next edge, clear main_valid and skid_valid, load NOP_INSTR, zero out_pc; any push or pop in that cycle SHALL be ignored.
REQ-030 Cycle after flush, in_ready SHALL be 1.

Reset
REQ-031 rst=1 at a clock edge SHALL set out_valid=0, skid empty, in_ready=1, out_pc=0, fields = NOP_INSTR slices, is_rtype=0.
REQ-032 rst SHALL take priority over flush, in_valid and out_ready; mid-operation reset SHALL discard both entries.
REQ-033 While rst=1 no instruction SHALL be accepted or presented.

Verification
REQ-034 Push 32'h2128FFFC (addi $8,$9,-4), pc 0x40, out_ready=1 -> next cycle out_valid=1, opcode=6'h08, rs=9, rt=8, imm16=16'hFFFC, out_pc=0x40, is_rtype=0.
REQ-035 Push 32'h012A4020 (add $8,$9,$10) -> opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=6'h20, is_rtype=1.
REQ-036 out_ready=0, push A then B -> in_ready=0 after B; A held stable; out_ready=1 -> A, then B next cycle, in_ready=1 again; push C while full -> C not accepted.
REQ-037 Stream 8 words, in_valid=out_ready=1 every cycle -> 8 consecutive outputs, in order, first one cycle after first push.
REQ-038 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, fields = NOP_INSTR; flushed-cycle input never appears.
REQ-039 rst=1 with both entries full and out_ready=1 -> next cycle out_valid=0, in_ready=1, out_pc=0; nothing consumed.

Source files
------------

// File: rtl/instr_decode_reg.sv
// Decode-stage pipeline register: a two-entry (main + skid) instruction buffer that
// presents MIPS field slices of the main word and a registered in_ready.
module instr_decode_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        is_rtype
);

  logic        main_valid_q, main_valid_d;
  logic [31:0] main_instr_q, main_instr_d;
  logic [31:0] main_pc_q,    main_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic        push_s;
  logic        pop_s;

  assign push_s = in_valid && !skid_valid_q;
  assign pop_s  = main_valid_q && out_ready;

  // Next-state selection for the main and skid entries
  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_instr_d = NOP_INSTR;
      main_pc_d    = 32'd0;
      skid_valid_d = 1'b0;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = 32'd0;
    end else if (pop_s) begin
      // A full buffer never pushes (in_ready low), so a pop there only promotes skid
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
        skid_instr_d = NOP_INSTR;
        skid_pc_d    = 32'd0;
      end else if (push_s) begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end else begin
        main_valid_d = 1'b0;
        main_instr_d = NOP_INSTR;
        main_pc_d    = 32'd0;
      end
    end else if (push_s) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end else begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Main word already holds NOP_INSTR when empty, so fields are plain slices
  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_pc    = main_pc_q;
  assign opcode    = main_instr_q[31:26];
  assign rs        = main_instr_q[25:21];
  assign rt        = main_instr_q[20:16];
  assign rd        = main_instr_q[15:11];
  assign shamt     = main_instr_q[10:6];
  assign funct     = main_instr_q[5:0];
  assign imm16     = main_instr_q[15:0];
  assign jaddr     = main_instr_q[25:0];
  assign is_rtype  = main_valid_q && (main_instr_q[31:26] == 6'b000000);

endmodule
